// File: rtl/count_display_driver_if.sv
// rtl/count_display_driver_if.sv - value/BCD/display bundle between counter, driver and board pins
// Purpose: groups the binary input, the converted BCD result and the display pins.
// Signals:
//   value [N-1:0]  binary value to display (from the counter)
//   bcd   [11:0]   last converted {hundreds, tens, ones}
//   valid          one-cycle pulse when bcd/ovf update
//   ovf            last converted value > 999
//   seg   [6:0]    {g,f,e,d,c,b,a}, active-low
//   an    [2:0]    digit enables, active-low; bit0 ones, bit1 tens, bit2 hundreds
// Modports: master = value source / display consumer, slave = the driver.
interface count_display_driver_if #(
  parameter int N = 16
);
  logic [N-1:0] value;
  logic [11:0]  bcd;
  logic         valid;
  logic         ovf;
  logic [6:0]   seg;
  logic [2:0]   an;

  modport master (output value, input bcd, valid, ovf, seg, an);
  modport slave  (input value, output bcd, valid, ovf, seg, an);
endinterface

// File: rtl/count_display_driver.sv
// rtl/count_display_driver.sv - binary to BCD converter with 3-digit multiplexed 7-segment driver
// Purpose: free-running double-dabble conversion of bus.value (one result every N+2
//   cycles) and a time-multiplexed common-anode display of the registered result.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous reset, active-high
//   bus  count_display_driver_if.slave: value in; bcd, valid, ovf, seg, an out
module count_display_driver #(
  parameter int N          = 16,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LEAD = 1
) (
  input logic                   clk,
  input logic                   rst,
  count_display_driver_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   sreg;
  logic [19:0]    acc;
  logic [19:0]    acc_adj;
  logic [CW-1:0]  cnt;

  logic [SW-1:0]  scan_cnt;
  logic [1:0]     idx;
  logic [1:0]     idx_nxt;
  logic [3:0]     nib;
  logic           blank;
  logic [6:0]     seg_nxt;
  logic [2:0]     an_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Pre-shift correction: any nibble >= 5 would exceed 9 after doubling, so add 3.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      sreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      bus.bcd   <= '0;
      bus.valid <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        LOAD: begin
          sreg  <= bus.value;
          acc   <= '0;
          cnt   <= CW'(N);
          state <= SHIFT;
        end
        SHIFT: begin
          {acc, sreg} <= {acc_adj, sreg} << 1;
          cnt         <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bus.bcd   <= acc[11:0];
          bus.ovf   <= |acc[19:12];
          bus.valid <= 1'b1;
          state     <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Decode the digit that becomes active at the next wrap, so an and seg change together.
  always_comb begin
    idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    nib     = bus.bcd[3:0];
    blank   = 1'b0;
    case (idx_nxt)
      2'd1: begin
        nib   = bus.bcd[7:4];
        blank = (BLANK_LEAD != 0) && (bus.bcd[11:4] == 8'd0);
      end
      2'd2: begin
        nib   = bus.bcd[11:8];
        blank = (BLANK_LEAD != 0) && (bus.bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg_nxt = bus.ovf ? SEG_DASH : (blank ? SEG_BLANK : seg_code(nib));
    an_nxt  = ~(3'b001 << idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd2;
      bus.an   <= 3'b111;
      bus.seg  <= SEG_BLANK;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx_nxt;
      bus.an   <= an_nxt;
      bus.seg  <= seg_nxt;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// tb/tb_count_display_driver.sv - self-checking bench for count_display_driver
module tb_count_display_driver;

  localparam int N    = 16;
  localparam int SCAN = 4;
  localparam int CONV = N + 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] value_drv;
  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  count_display_driver_if #(.N(N)) bus0 ();
  count_display_driver_if #(.N(N)) bus1 ();
  assign bus0.value = value_drv;
  assign bus1.value = value_drv;

  count_display_driver #(.N(N), .SCAN_DIV(SCAN), .BLANK_LEAD(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  count_display_driver #(.N(N), .SCAN_DIV(SCAN), .BLANK_LEAD(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout at %0t", nm, $time);
  endtask

  // Display pattern of digit d (0 ones, 1 tens, 2 hundreds) for a decimal value v in 0..999.
  function automatic logic [6:0] disp(input int d, input int v, input bit o, input bit bl);
    int digit;
    if (o) return 7'b0111111;
    digit = (d == 0) ? v % 10 : (d == 1) ? (v / 10) % 10 : v / 100;
    if (bl && d == 2 && v < 100) return 7'b1111111;
    if (bl && d == 1 && v < 10) return 7'b1111111;
    return seg_tbl[digit];
  endfunction

  // Model: conversion every CONV cycles from the first edge after reset, display rotates
  // every SCAN cycles and shows the result held at the time of the rotation.
  int         m_edges, m_sample, m_val, m_idx;
  bit         m_ovf, m_valid;
  logic [2:0] m_an;
  logic [6:0] m_seg0, m_seg1;

  always @(posedge clk) begin
    if (rst) begin
      m_edges <= 0; m_val <= 0; m_ovf <= 1'b0; m_valid <= 1'b0;
      m_idx <= 2; m_an <= 3'b111; m_seg0 <= 7'h7f; m_seg1 <= 7'h7f;
    end else begin
      if (m_edges % CONV == 0) m_sample <= int'(value_drv);
      m_valid <= (m_edges % CONV == CONV - 1);
      if (m_edges % CONV == CONV - 1) begin
        m_val <= m_sample % 1000;
        m_ovf <= (m_sample > 999);
      end
      if (m_edges % SCAN == SCAN - 1) begin
        m_idx  <= (m_idx + 1) % 3;
        m_an   <= ~(3'b001 << ((m_idx + 1) % 3));
        m_seg0 <= disp((m_idx + 1) % 3, m_val, m_ovf, 1'b1);
        m_seg1 <= disp((m_idx + 1) % 3, m_val, m_ovf, 1'b0);
      end
      m_edges <= m_edges + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_valid", bus0.valid, m_valid);
      chk("cmp_bcd", bus0.bcd, {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)});
      chk("cmp_ovf", bus0.ovf, m_ovf);
      chk("cmp_an", bus0.an, m_an);
      chk("cmp_seg", bus0.seg, m_seg0);
      chk("cmp_an_bl0", bus1.an, m_an);
      chk("cmp_seg_bl0", bus1.seg, m_seg1);
    end
  end

  task automatic drive(input int v);
    value_drv = N'(v);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!bus0.valid && cyc < 200);
    if (!bus0.valid) timeout("wait_valid");
  endtask

  task automatic check_digit(input string nm, input logic [2:0] tgt, input logic [6:0] e0, input logic [6:0] e1);
    int n = 0;
    while (bus0.an !== tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus0.an !== tgt) timeout(nm);
    else begin
      chk(nm, bus0.seg, e0);
      chk({nm, "_bl0"}, bus1.seg, e1);
    end
  endtask

  task automatic new_value(input int v);
    int lat;
    drive(v);
    wait_valid(lat);
    wait_valid(lat);
    repeat (SCAN) @(negedge clk);
  endtask

  initial begin
    int lat, c;
    bit found;
    rst = 1'b1;
    drive(0);
    @(posedge clk);
    check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_an", bus0.an, 3'b111);
    chk("rst_seg", bus0.seg, 7'b1111111);
    chk("rst_bcd", bus0.bcd, 12'h000);
    chk("rst_valid", bus0.valid, 1'b0);
    chk("rst_ovf", bus0.ovf, 1'b0);

    rst = 1'b0;
    wait_valid(lat);
    chk("first_valid_latency", lat, 18);
    chk("zero_bcd", bus0.bcd, 12'h000);
    chk("zero_ovf", bus0.ovf, 1'b0);
    check_digit("zero_ones", 3'b110, 7'b1000000, 7'b1000000);
    check_digit("zero_tens", 3'b101, 7'b1111111, 7'b1000000);
    check_digit("zero_hund", 3'b011, 7'b1111111, 7'b1000000);

    new_value(100);
    chk("v100_bcd", bus0.bcd, 12'h100);
    check_digit("v100_ones", 3'b110, 7'b1000000, 7'b1000000);
    check_digit("v100_tens", 3'b101, 7'b1000000, 7'b1000000);
    check_digit("v100_hund", 3'b011, 7'b1111001, 7'b1111001);

    new_value(57);
    chk("v57_bcd", bus0.bcd, 12'h057);
    check_digit("v57_ones", 3'b110, 7'b1111000, 7'b1111000);
    check_digit("v57_tens", 3'b101, 7'b0010010, 7'b0010010);
    check_digit("v57_hund", 3'b011, 7'b1111111, 7'b1000000);

    new_value(1000);
    chk("v1000_ovf", bus0.ovf, 1'b1);
    chk("v1000_bcd", bus0.bcd, 12'h000);
    check_digit("v1000_ones", 3'b110, 7'b0111111, 7'b0111111);
    check_digit("v1000_tens", 3'b101, 7'b0111111, 7'b0111111);
    check_digit("v1000_hund", 3'b011, 7'b0111111, 7'b0111111);

    new_value(999);
    chk("v999_ovf", bus0.ovf, 1'b0);
    chk("v999_bcd", bus0.bcd, 12'h999);
    check_digit("v999_hund", 3'b011, 7'b0010000, 7'b0010000);

    new_value(65535);
    chk("vmax_ovf", bus0.ovf, 1'b1);
    chk("vmax_bcd", bus0.bcd, 12'h535);

    drive(42);
    wait_valid(lat);
    repeat (6) @(negedge clk);
    drive(43);
    wait_valid(lat);
    chk("v42_held_bcd", bus0.bcd, 12'h042);
    wait_valid(lat);
    chk("v43_bcd", bus0.bcd, 12'h043);
    chk("conv_period", lat, 18);

    wait_valid(lat);
    c = 0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      c = bus0.valid ? 0 : c + 1;
      if (bus0.an === 3'b101 && c >= 3 && c <= 14) found = 1'b1;
    end
    if (!found) timeout("mid_shift_search");
    else begin
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_an", bus0.an, 3'b111);
      chk("midrst_seg", bus0.seg, 7'b1111111);
      chk("midrst_bcd", bus0.bcd, 12'h000);
      chk("midrst_valid", bus0.valid, 1'b0);
      rst = 1'b0;
      wait_valid(lat);
      chk("midrst_latency", lat, 18);
      chk("midrst_bcd_after", bus0.bcd, 12'h043);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
